input_unit: RTL and testbench

INPUT_UNIT -- requirements
Module: input_unit

---
 rtl/input_unit.sv | 88 ++++++++
 tb/tb_input_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/input_unit.sv
// Router input unit: credit-flow-controlled circular flit FIFO with head-of-line
// route decode, registered credit return and a sticky overflow flag.
module input_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_data_valid,
  output logic                           credit_out,
  output logic [DATA_WIDTH-1:0]          head_data,
  output logic                           head_valid,
  output logic [3:0]                     route_req,
  input  logic                           grant,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic                           overflow_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_C = AW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  credit_q;
  logic                  ovf_q, ovf_d;
  logic                  rd_en, wr_en;
  logic [1:0]            route_code;

  // A full buffer still accepts a write when the head leaves on the same edge.
  always_comb begin
    rd_en    = grant && (count_q != '0);
    wr_en    = in_data_valid && ((count_q != FULL_C) || rd_en);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (rd_en) rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + AW'(1);
    if (wr_en) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + AW'(1);
    if (wr_en && !rd_en)      count_d = count_q + CW'(1);
    else if (rd_en && !wr_en) count_d = count_q - CW'(1);
    ovf_d = ovf_q | (in_data_valid & ~wr_en);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      credit_q <= rd_en;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the count is zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    head_valid = (count_q != '0);
    head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    route_code = head_data[DATA_WIDTH-1 -: 2];
    route_req  = 4'b0000;
    if (head_valid) begin
      case (route_code)
        2'd0:    route_req = 4'b0001;
        2'd1:    route_req = 4'b0010;
        2'd2:    route_req = 4'b0100;
        default: route_req = 4'b1000;
      endcase
    end
  end

  assign credit_out   = credit_q;
  assign occupancy    = count_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_input_unit.sv
// Self-checking bench for input_unit: directed scenarios plus a randomized,
// credit-respecting traffic phase, all checked against a queue-based model.
module tb_input_unit;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_data_valid;
  logic          credit_out;
  logic [DW-1:0] head_data;
  logic          head_valid;
  logic [3:0]    route_req;
  logic          grant;
  logic [CW-1:0] occupancy;
  logic          overflow_err;

  input_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_data_valid(in_data_valid),
    .credit_out(credit_out), .head_data(head_data), .head_valid(head_valid),
    .route_req(route_req), .grant(grant), .occupancy(occupancy),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [DW-1:0] q[$];
  logic          m_credit;
  logic          m_ovf;
  int            up_cred;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_credit = 1'b0;
    m_ovf    = 1'b0;
    up_cred  = DEPTH;
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] h;
    logic [3:0]    r;
    h = (q.size() > 0) ? q[0] : '0;
    r = (q.size() > 0) ? (4'b0001 << h[DW-1 -: 2]) : 4'b0000;
    chk({tag, ".occ"},    DW'(occupancy),  DW'(q.size()));
    chk({tag, ".hvalid"}, DW'(head_valid), DW'(q.size() > 0));
    chk({tag, ".hdata"},  head_data,       h);
    chk({tag, ".route"},  DW'(route_req),  DW'(r));
    chk({tag, ".credit"}, DW'(credit_out), DW'(m_credit));
    chk({tag, ".ovf"},    DW'(overflow_err), DW'(m_ovf));
  endtask

  // Drive one cycle: inputs set at the falling edge, model advanced at the
  // rising edge, outputs compared at the next falling edge.
  task automatic step(input string tag, input logic v, input logic [DW-1:0] d, input logic g);
    bit rd, wr;
    in_data_valid = v;
    in_data       = d;
    grant         = g;
    @(posedge clk);
    if (m_credit) up_cred++;
    rd = g && (q.size() > 0);
    wr = v && ((q.size() < DEPTH) || rd);
    if (rd) void'(q.pop_front());
    if (wr) begin
      q.push_back(d);
      up_cred--;
    end
    if (v && !wr) m_ovf = 1'b1;
    m_credit = rd;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int pulses;
    rst = 1'b0;
    in_data = '0;
    in_data_valid = 1'b0;
    grant = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b1;

    // Fill then drain, route code 3 on every flit
    for (int i = 1; i <= 4; i++) step("fill", 1'b1, 32'hC000_0000 + DW'(i), 1'b0);
    chk("fill.occ4", DW'(occupancy), DW'(4));
    for (int i = 0; i < 4; i++) begin
      chk("drain.route", DW'(route_req), DW'(4'b1000));
      step("drain", 1'b0, '0, 1'b1);
    end
    step("drain.tail", 1'b0, '0, 1'b0);

    // Full with simultaneous read and write
    for (int i = 0; i < 4; i++) step("refill", 1'b1, 32'h8000_0010 + DW'(i), 1'b0);
    step("full.rw", 1'b1, 32'h0000_00AA, 1'b1);
    chk("full.rw.occ", DW'(occupancy), DW'(4));
    chk("full.rw.ovf", DW'(overflow_err), '0);

    // Overflow: dropped flit, sticky flag
    step("ovf", 1'b1, 32'h4000_0BAD, 1'b0);
    chk("ovf.flag", DW'(overflow_err), DW'(1));
    for (int i = 0; i < 10; i++) step("ovf.idle", 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step("ovf.drain", 1'b0, '0, 1'b1);

    // Grants on an empty buffer
    for (int i = 0; i < 3; i++) step("empty.grant", 1'b0, '0, 1'b1);
    step("empty.idle", 1'b0, '0, 1'b0);

    // Twelve flits with grants trailing by one cycle
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      step("wrap", (i < 12), {DW'(i % 4) << (DW - 2)} | DW'(i + 100), (i >= 1 && i <= 12));
      if (credit_out === 1'b1) pulses++;
    end
    chk("wrap.pulses", DW'(pulses), DW'(12));

    // Reset asserted between edges with three flits stored
    for (int i = 0; i < 3; i++) step("pre.rst", 1'b1, 32'h8000_0100 + DW'(i), 1'b0);
    in_data_valid = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("midrst.occ",    DW'(occupancy),  '0);
    chk("midrst.hvalid", DW'(head_valid), '0);
    chk("midrst.credit", DW'(credit_out), '0);
    chk("midrst.ovf",    DW'(overflow_err), '0);
    @(negedge clk);
    check_all("midrst.hold");
    rst = 1'b1;
    step("post.rst.wr", 1'b1, 32'h4000_0000, 1'b0);
    chk("post.rst.route", DW'(route_req), DW'(4'b0010));
    step("post.rst.rd", 1'b0, '0, 1'b1);
    step("post.rst.idle", 1'b0, '0, 1'b0);

    // Randomized traffic honouring upstream credits; conservation checked each cycle
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic v, g;
      v = (up_cred > 0) && ($urandom_range(0, 99) < 60);
      g = ($urandom_range(0, 99) < 50);
      step("rand", v, $urandom, g);
      chk("rand.conserve", DW'(up_cred + int'(occupancy) + int'(credit_out)), DW'(DEPTH));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
